// File: rtl/debounce_scheduler.sv
// Bank debouncer: NUM_BTN synchronized buttons share one counter, granted round-robin.
// Define DEBOUNCE_SCHED_FIXED_PRIO_EN to grant the lowest pending index instead.
module debounce_scheduler #(
    parameter int NUM_BTN = 4,
    parameter int CNT_W = 20,
    parameter logic [CNT_W-1:0] DEBOUNCE_CNT = 20'hF_FFFF,
    parameter int IDX_W = $clog2(NUM_BTN)
) (
    input  logic               clkIn,
    input  logic               rstIn,
    input  logic [NUM_BTN-1:0] buttonIn,
    output logic [NUM_BTN-1:0] buttonOut,
    output logic [NUM_BTN-1:0] changeOut,
    output logic               busyOut,
    output logic [IDX_W-1:0]   activeIdxOut
);

    typedef enum logic {IDLE, COUNT} stateType;

    stateType           state;
    logic [NUM_BTN-1:0] s1;
    logic [NUM_BTN-1:0] s2;
    logic [NUM_BTN-1:0] pending;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   releasePtr;

    assign pending      = s2 ^ buttonOut;
    assign activeIdxOut = idx;

`ifdef DEBOUNCE_SCHED_FIXED_PRIO_EN
    assign releasePtr = '0;
`else
    assign releasePtr = (idx == IDX_W'(NUM_BTN - 1)) ? '0 : idx + IDX_W'(1);
`endif

    // Scan starting at ptr and wrap, so the most recently served button goes last.
    always_comb begin
        int j;
        logic found;
        logic [IDX_W-1:0] cand;
        j      = 0;
        found  = 1'b0;
        cand   = '0;
        winner = ptr;
        for (int k = 0; k < NUM_BTN; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_BTN) begin
                j = j - NUM_BTN;
            end
            cand = IDX_W'(j);
            if (!found && pending[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state     <= IDLE;
            s1        <= '0;
            s2        <= '0;
            cnt       <= '0;
            idx       <= '0;
            ptr       <= '0;
            buttonOut <= '0;
            changeOut <= '0;
            busyOut   <= 1'b0;
        end else begin
            s1        <= buttonIn;
            s2        <= s1;
            changeOut <= '0;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        idx     <= winner;
                        cnt     <= '0;
                        state   <= COUNT;
                        busyOut <= 1'b1;
                    end
                end
                COUNT: begin
                    // Revert beats bounce, bounce beats commit.
                    if (s2[idx] == buttonOut[idx]) begin
                        ptr     <= releasePtr;
                        state   <= IDLE;
                        busyOut <= 1'b0;
                    end else if (s1[idx] != s2[idx]) begin
                        cnt <= '0;
                    end else if (cnt == DEBOUNCE_CNT) begin
                        buttonOut[idx] <= s2[idx];
                        changeOut[idx] <= 1'b1;
                        ptr            <= releasePtr;
                        state          <= IDLE;
                        busyOut        <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    busyOut <= 1'b0;
                end
            endcase
        end
    end

endmodule
